// File: rtl/apb_pkg.sv
// Shared APB constants: completer state encoding, default bus widths, wait counter width.
package apb_pkg;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

  localparam int unsigned APB_ADDR_WIDTH = 8;
  localparam int unsigned APB_DATA_WIDTH = 16;
  localparam int unsigned APB_CNT_WIDTH  = 4;

endpackage

// File: rtl/apb_regfile_mem.sv
// Register-file storage: synchronous write, combinational read, synchronous clear.
module apb_regfile_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  waddr_ok;
  logic                  raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_LIM);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_LIM);

  // Storage update: clear wipes every word, otherwise write one in-range word.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '{default: '0};
    end else if (we && waddr_ok) begin
      mem[IDX_W'(waddr)] <= wdata;
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    rdata_c = '0;
    if (raddr_ok) begin
      rdata_c = mem[IDX_W'(raddr)];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states and an out-of-range error response.
// APB_SETUP marks the cycle right after a completion, where a back-to-back setup
// may already be on the bus; it accepts a new setup exactly like APB_IDLE does.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam logic [ADDR_WIDTH:0]        DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [APB_CNT_WIDTH-1:0]   WAIT_INIT = APB_CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [APB_CNT_WIDTH-1:0]   CNT_ONE   = APB_CNT_WIDTH'(1);

  logic [1:0]               state;
  logic [1:0]               next_state;
  logic                     setup_c;
  logic                     complete_c;
  logic                     dec_c;
  logic                     err_c;
  logic                     we_c;
  logic [DATA_WIDTH-1:0]    rdata_c;

  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     err_q;
  logic [APB_CNT_WIDTH-1:0] cnt_q;

  assign err_c = ({1'b0, PADDR} >= DEPTH_LIM);
  assign we_c  = complete_c && write_q && !err_q;

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= APB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and transfer-event decode.
  always_comb begin
    next_state = state;
    setup_c    = 1'b0;
    complete_c = 1'b0;
    dec_c      = 1'b0;
    case (state)
      APB_IDLE, APB_SETUP: begin
        if (PSEL && !PENABLE) begin
          setup_c    = 1'b1;
          next_state = APB_ACCESS;
        end else begin
          next_state = APB_IDLE;
        end
      end
      APB_ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          next_state = APB_IDLE;
        end else if (PREADY) begin
          complete_c = 1'b1;
          next_state = APB_SETUP;
        end else begin
          dec_c = 1'b1;
        end
      end
      default: next_state = APB_IDLE;
    endcase
  end

  // Setup latches, wait countdown and registered response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else if (setup_c) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      err_q   <= err_c;
      cnt_q   <= WAIT_INIT;
      PREADY  <= (WAIT_INIT == '0);
      PSLVERR <= (WAIT_INIT == '0) && err_c;
      if (!PWRITE) begin
        PRDATA <= err_c ? '0 : rdata_c;
      end
    end else if (dec_c) begin
      cnt_q   <= cnt_q - CNT_ONE;
      PREADY  <= (cnt_q == CNT_ONE);
      PSLVERR <= (cnt_q == CNT_ONE) && err_q;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end
  end

  apb_regfile_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk    (PCLK),
    .clr    (PRESET),
    .we     (we_c),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (PADDR),
    .rdata_c(rdata_c)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers (0, 1 and 3 wait states) on one shared APB bus with one-hot PSEL.
module tb_apb_slave_regfile;

  logic        clk;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [2:0]  ready;
  logic [2:0]  slverr;
  logic [15:0] prdata [3];

  int tests = 0;
  int fails = 0;

  // Reference model: per-instance word storage and last read value.
  logic [15:0] mdl_mem [3][64];
  logic [15:0] mdl_prd [3];

  apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(ready[0]), .PRDATA(prdata[0]), .PSLVERR(slverr[0]));
  apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_DEPTH(64), .WAIT_CYCLES(1)) u_w1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(ready[1]), .PRDATA(prdata[1]), .PSLVERR(slverr[1]));
  apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(ready[2]), .PRDATA(prdata[2]), .PSLVERR(slverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    psel    = 3'b000;
    penable = 1'b0;
    tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mdl_prd[i] = 16'h0000;
      for (int j = 0; j < 64; j++) mdl_mem[i][j] = 16'h0000;
    end
  endtask

  // Drive SETUP, then ACCESS until PREADY (bounded); bus address/data scrambled during ACCESS.
  task automatic run_xfer(input int idx, input logic [7:0] a, input logic wr, input logic [15:0] d,
                          output int cyc, output logic [15:0] gd, output logic ge);
    bit done;
    psel    = 3'(1 << idx);
    penable = 1'b0;
    paddr   = a;
    pwrite  = wr;
    pwdata  = d;
    tick();
    penable = 1'b1;
    paddr   = 8'($urandom);
    pwdata  = 16'($urandom);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      if (ready[idx]) done = 1'b1;
      else tick();
    end
    gd = prdata[idx];
    ge = slverr[idx];
    tick();
  endtask

  // One full transfer checked against the model: latency, error, read data, PREADY drop.
  task automatic do_xfer(input int idx, input logic [7:0] a, input logic wr, input logic [15:0] d);
    int          cyc;
    logic [15:0] gd;
    logic        ge;
    logic        err;
    err = (a >= 8'd64);
    if (!wr) mdl_prd[idx] = err ? 16'h0000 : mdl_mem[idx][a[5:0]];
    run_xfer(idx, a, wr, d, cyc, gd, ge);
    chk($sformatf("latency i%0d a%02h", idx, a), 32'(cyc), 32'(wait_of(idx) + 1));
    chk($sformatf("pslverr i%0d a%02h", idx, a), 32'(ge), 32'(err));
    chk($sformatf("prdata i%0d a%02h w%0d", idx, a, wr), 32'(gd), 32'(mdl_prd[idx]));
    chk($sformatf("ready_drop i%0d", idx), 32'(ready[idx]), 32'd0);
    if (wr && !err) mdl_mem[idx][a[5:0]] = d;
  endtask

  initial begin
    int          r;
    int          idx;
    logic [7:0]  a;
    logic        wr;
    logic [15:0] d;

    psel    = 3'b000;
    penable = 1'b0;
    paddr   = 8'h00;
    pwrite  = 1'b0;
    pwdata  = 16'h0000;
    preset  = 1'b1;
    model_clear();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready i%0d", i), 32'(ready[i]), 32'd0);
      chk($sformatf("reset_pslverr i%0d", i), 32'(slverr[i]), 32'd0);
      chk($sformatf("reset_prdata i%0d", i), 32'(prdata[i]), 32'd0);
    end
    preset = 1'b0;
    go_idle();

    // Read after reset, then write/read with one wait state.
    do_xfer(1, 8'h05, 1'b0, 16'h0000);
    go_idle();
    do_xfer(1, 8'h05, 1'b1, 16'hBEEF);
    go_idle();
    do_xfer(1, 8'h05, 1'b0, 16'h0000);
    chk("beef_readback", 32'(prdata[1]), 32'h0000BEEF);
    go_idle();

    // Zero wait states, back-to-back write then read of the same word.
    do_xfer(0, 8'h3F, 1'b1, 16'h1234);
    do_xfer(0, 8'h3F, 1'b0, 16'h0000);
    chk("b2b_readback", 32'(prdata[0]), 32'h00001234);
    go_idle();

    // Out-of-range write and read; top word must be untouched.
    do_xfer(1, 8'h40, 1'b1, 16'hFFFF);
    go_idle();
    do_xfer(1, 8'h40, 1'b0, 16'h0000);
    go_idle();
    do_xfer(1, 8'h3F, 1'b0, 16'h0000);
    go_idle();

    // Abort: drop PSEL during wait states on the 3-wait instance.
    psel = 3'b100; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1; pwdata = 16'hAAAA;
    tick();
    penable = 1'b1;
    tick();
    chk("abort_wait_ready", 32'(ready[2]), 32'd0);
    psel = 3'b000; penable = 1'b0;
    tick();
    chk("abort_ready", 32'(ready[2]), 32'd0);
    chk("abort_pslverr", 32'(slverr[2]), 32'd0);
    tick();
    do_xfer(2, 8'h10, 1'b0, 16'h0000);
    go_idle();

    // Reset in the middle of an ACCESS phase clears memory.
    do_xfer(2, 8'h11, 1'b1, 16'h5A5A);
    go_idle();
    psel = 3'b100; penable = 1'b0; paddr = 8'h12; pwrite = 1'b1; pwdata = 16'h7777;
    tick();
    penable = 1'b1;
    preset  = 1'b1;
    tick();
    chk("midreset_ready", 32'(ready[2]), 32'd0);
    chk("midreset_prdata", 32'(prdata[2]), 32'd0);
    preset = 1'b0;
    model_clear();
    go_idle();
    do_xfer(2, 8'h11, 1'b0, 16'h0000);
    go_idle();
    do_xfer(0, 8'h3F, 1'b0, 16'h0000);
    go_idle();

    // Protocol violation: PSEL and PENABLE together with no setup.
    psel = 3'b010; penable = 1'b1; paddr = 8'h07; pwrite = 1'b1; pwdata = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("violation_ready c%0d", k), 32'(ready[1]), 32'd0);
    end
    go_idle();
    do_xfer(1, 8'h07, 1'b0, 16'h0000);
    go_idle();

    // Randomized traffic over a small address set so reads hit earlier writes.
    for (int n = 0; n < 120; n++) begin
      idx = $urandom_range(0, 2);
      r   = $urandom_range(0, 11);
      a   = (r < 8) ? 8'(r) : (r == 8) ? 8'h3F : (r == 9) ? 8'h40 : (r == 10) ? 8'h3E : 8'hFF;
      wr  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      do_xfer(idx, a, wr, d);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
